// File: rtl/oaram_packer.sv
// oaram_packer: compresses a dense stream of 8-bit activations into
// (value, zero-run index) entries and writes them to the output activation RAM.
// A zero run that reaches the largest index emits a filler entry of value 0.
// Zero beats still pending when the group ends are dropped, not written.
// Optional build macro: OARAM_PACKER_RELU_EN. When it is defined, in_value is
// treated as signed and negative values count as zero (ReLU). When it is not
// defined, only the value 0 counts as zero.
module oaram_packer #(
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [RAM_WIDTH-1:0]   base_address,
  input  logic                   in_valid,
  input  logic [7:0]             in_value,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [7:0]             oaram_value,
  output logic [INDEX_WIDTH-1:0] oaram_index,
  output logic [RAM_WIDTH-1:0]   oaram_address,
  output logic                   oaram_write_enable,
  output logic                   done,
  output logic [RAM_WIDTH:0]     entry_count,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] RUN_MAX  = {INDEX_WIDTH{1'b1}};
  localparam logic [INDEX_WIDTH-1:0] RUN_ZERO = {INDEX_WIDTH{1'b0}};
  localparam logic [RAM_WIDTH-1:0]   PTR_MAX  = {RAM_WIDTH{1'b1}};

  state_t                 state_r;
  logic [RAM_WIDTH-1:0]   ptr_r;
  logic [INDEX_WIDTH-1:0] run_r;

  logic                   beat_s;
  logic                   zero_s;
  logic                   write_req_s;
  logic [7:0]             write_value_s;
  logic [INDEX_WIDTH-1:0] write_index_s;
  logic [INDEX_WIDTH-1:0] run_next_s;

  // Decides whether a beat is a zero for packing purposes.
  function automatic logic is_zero(input logic [7:0] v);
`ifdef OARAM_PACKER_RELU_EN
    return (v == 8'd0) || v[7];
`else
    return (v == 8'd0);
`endif
  endfunction

  // Classify the current beat and work out the entry it produces, if any.
  always_comb begin
    beat_s        = in_valid && in_ready;
    zero_s        = is_zero(in_value);
    write_req_s   = 1'b0;
    write_value_s = 8'd0;
    write_index_s = run_r;
    run_next_s    = run_r;
    if (!beat_s) begin
      run_next_s = run_r;
    end else if (!zero_s) begin
      write_req_s   = 1'b1;
      write_value_s = in_value;
      write_index_s = run_r;
      run_next_s    = RUN_ZERO;
    end else if (in_last) begin
      // Trailing zeros at the end of the group are discarded.
      run_next_s = RUN_ZERO;
    end else if (run_r == RUN_MAX) begin
      write_req_s   = 1'b1;
      write_value_s = 8'd0;
      write_index_s = RUN_MAX;
      run_next_s    = RUN_ZERO;
    end else begin
      run_next_s = run_r + 1'b1;
    end
  end

  // Group state machine with registered RAM write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r            <= IDLE;
      in_ready           <= 1'b0;
      oaram_write_enable <= 1'b0;
      done               <= 1'b0;
      overflow           <= 1'b0;
      entry_count        <= {(RAM_WIDTH+1){1'b0}};
      oaram_value        <= 8'd0;
      oaram_index        <= RUN_ZERO;
      oaram_address      <= {RAM_WIDTH{1'b0}};
      run_r              <= RUN_ZERO;
      ptr_r              <= {RAM_WIDTH{1'b0}};
    end else begin
      oaram_write_enable <= 1'b0;
      done               <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            ptr_r       <= base_address;
            run_r       <= RUN_ZERO;
            entry_count <= {(RAM_WIDTH+1){1'b0}};
            overflow    <= 1'b0;
            in_ready    <= 1'b1;
            state_r     <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          run_r <= run_next_s;
          // Once the last address has been written, the group keeps
          // consuming beats but nothing more reaches the RAM.
          if (write_req_s && !overflow) begin
            oaram_write_enable <= 1'b1;
            oaram_value        <= write_value_s;
            oaram_index        <= write_index_s;
            oaram_address      <= ptr_r;
            ptr_r              <= ptr_r + 1'b1;
            entry_count        <= entry_count + 1'b1;
            if (ptr_r == PTR_MAX) begin
              overflow <= 1'b1;
            end else begin
              overflow <= overflow;
            end
          end else begin
            ptr_r <= ptr_r;
          end
          if (beat_s && in_last) begin
            in_ready <= 1'b0;
            done     <= 1'b1;
            state_r  <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oaram_packer.sv
// Directed self-checking bench for oaram_packer (default parameters).
module tb_oaram_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] base_address;
  logic       in_valid;
  logic [7:0] in_value;
  logic       in_last;
  logic       in_ready;
  logic [7:0] oaram_value;
  logic [3:0] oaram_index;
  logic [9:0] oaram_address;
  logic       oaram_write_enable;
  logic       done;
  logic [10:0] entry_count;
  logic       overflow;

  oaram_packer #(.RAM_WIDTH(10), .INDEX_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .in_valid(in_valid), .in_value(in_value), .in_last(in_last),
    .in_ready(in_ready), .oaram_value(oaram_value), .oaram_index(oaram_index),
    .oaram_address(oaram_address), .oaram_write_enable(oaram_write_enable),
    .done(done), .entry_count(entry_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Cycle counter and write/done monitor (sampled on the falling edge).
  int         cyc = 0;
  int         cap_n = 0;
  int         done_cnt = 0;
  logic [7:0] cap_val  [0:63];
  logic [3:0] cap_idx  [0:63];
  logic [9:0] cap_addr [0:63];
  int         cap_cyc  [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (oaram_write_enable && cap_n < 64) begin
      cap_val[cap_n]  <= oaram_value;
      cap_idx[cap_n]  <= oaram_index;
      cap_addr[cap_n] <= oaram_address;
      cap_cyc[cap_n]  <= cyc;
      cap_n           <= cap_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  logic [7:0] beats [0:31];
  int         drv_cyc [0:31];

  task automatic start_group(input logic [9:0] base);
    @(negedge clk);
    start = 1'b1;
    base_address = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_value = beats[i];
      in_last  = use_last && (i == n - 1);
      drv_cyc[i] = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_value = 8'd0;
  endtask

  task automatic wait_done(input int done0);
    for (int t = 0; t < 20 && done_cnt == done0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base_address = 10'h000;
    in_valid = 1'b0; in_value = 8'd0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (oaram_write_enable !== 1'b0) $display("FAIL reset_we got %0b want 0", oaram_write_enable); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else pass_cnt++;
    total_cnt++; if (entry_count !== 11'd0) $display("FAIL reset_entry_count got %0d want 0", entry_count); else pass_cnt++;
    total_cnt++; if ({oaram_value, oaram_index, oaram_address} !== 22'd0)
      $display("FAIL reset_outputs got %h/%h/%h want 0/0/0", oaram_value, oaram_index, oaram_address); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int c0, d0;
    c0 = cap_n; d0 = done_cnt;
    start_group(10'h010);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %0b want 1", in_ready); else pass_cnt++;
    beats[0] = 8'd0; beats[1] = 8'd0; beats[2] = 8'd5; beats[3] = 8'd0; beats[4] = 8'd7;
    send_beats(5, 1'b1);
    wait_done(d0);
    total_cnt++; if (cap_n - c0 !== 2) $display("FAIL basic_writes got %0d want 2", cap_n - c0); else pass_cnt++;
    total_cnt++; if ({cap_val[c0], cap_idx[c0], cap_addr[c0]} !== {8'd5, 4'd2, 10'h010})
      $display("FAIL basic_entry0 got %h/%h/%h want 05/2/010", cap_val[c0], cap_idx[c0], cap_addr[c0]); else pass_cnt++;
    total_cnt++; if ({cap_val[c0+1], cap_idx[c0+1], cap_addr[c0+1]} !== {8'd7, 4'd1, 10'h011})
      $display("FAIL basic_entry1 got %h/%h/%h want 07/1/011", cap_val[c0+1], cap_idx[c0+1], cap_addr[c0+1]); else pass_cnt++;
    total_cnt++; if (cap_cyc[c0] !== drv_cyc[2] + 1)
      $display("FAIL basic_write_latency got %0d want %0d", cap_cyc[c0], drv_cyc[2] + 1); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (entry_count !== 11'd2) $display("FAIL basic_entry_count got %0d want 2", entry_count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_idle_ready got %0b want 0", in_ready); else pass_cnt++;
  endtask

  task automatic test_placeholder;
    int c0, d0;
    c0 = cap_n; d0 = done_cnt;
    start_group(10'h040);
    for (int i = 0; i < 17; i++) beats[i] = 8'd0;
    beats[17] = 8'd9;
    send_beats(18, 1'b1);
    wait_done(d0);
    total_cnt++; if (cap_n - c0 !== 2) $display("FAIL ph_writes got %0d want 2", cap_n - c0); else pass_cnt++;
    total_cnt++; if ({cap_val[c0], cap_idx[c0], cap_addr[c0]} !== {8'd0, 4'd15, 10'h040})
      $display("FAIL ph_entry0 got %h/%h/%h want 00/f/040", cap_val[c0], cap_idx[c0], cap_addr[c0]); else pass_cnt++;
    total_cnt++; if ({cap_val[c0+1], cap_idx[c0+1], cap_addr[c0+1]} !== {8'd9, 4'd1, 10'h041})
      $display("FAIL ph_entry1 got %h/%h/%h want 09/1/041", cap_val[c0+1], cap_idx[c0+1], cap_addr[c0+1]); else pass_cnt++;
    total_cnt++; if (entry_count !== 11'd2) $display("FAIL ph_entry_count got %0d want 2", entry_count); else pass_cnt++;
  endtask

  task automatic test_trailing;
    int c0, d0;
    c0 = cap_n; d0 = done_cnt;
    start_group(10'h100);
    beats[0] = 8'd3; beats[1] = 8'd0; beats[2] = 8'd0;
    send_beats(3, 1'b1);
    wait_done(d0);
    total_cnt++; if (cap_n - c0 !== 1) $display("FAIL trail_writes got %0d want 1", cap_n - c0); else pass_cnt++;
    total_cnt++; if ({cap_val[c0], cap_idx[c0], cap_addr[c0]} !== {8'd3, 4'd0, 10'h100})
      $display("FAIL trail_entry0 got %h/%h/%h want 03/0/100", cap_val[c0], cap_idx[c0], cap_addr[c0]); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL trail_done_pulses got %0d want 1", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (entry_count !== 11'd1) $display("FAIL trail_entry_count got %0d want 1", entry_count); else pass_cnt++;
  endtask

  task automatic test_overflow;
    int c0, d0;
    c0 = cap_n; d0 = done_cnt;
    start_group(10'h3FE);
    beats[0] = 8'd1; beats[1] = 8'd2; beats[2] = 8'd3; beats[3] = 8'd4;
    send_beats(4, 1'b1);
    wait_done(d0);
    total_cnt++; if (cap_n - c0 !== 2) $display("FAIL ovf_writes got %0d want 2", cap_n - c0); else pass_cnt++;
    total_cnt++; if ({cap_val[c0], cap_addr[c0], cap_val[c0+1], cap_addr[c0+1]} !== {8'd1, 10'h3FE, 8'd2, 10'h3FF})
      $display("FAIL ovf_entries got %h@%h %h@%h want 01@3fe 02@3ff", cap_val[c0], cap_addr[c0], cap_val[c0+1], cap_addr[c0+1]); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else pass_cnt++;
    total_cnt++; if (entry_count !== 11'd2) $display("FAIL ovf_entry_count got %0d want 2", entry_count); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL ovf_done_pulses got %0d want 1", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    int c0, d0;
    start_group(10'h020);
    beats[0] = 8'd1; beats[1] = 8'd2; beats[2] = 8'd3;
    send_beats(3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++; if ({in_ready, oaram_write_enable, done, overflow} !== 4'b0000)
      $display("FAIL mrst_flags got %b want 0000", {in_ready, oaram_write_enable, done, overflow}); else pass_cnt++;
    total_cnt++; if ({entry_count, oaram_value, oaram_index, oaram_address} !== 33'd0)
      $display("FAIL mrst_outputs got %0d/%h/%h/%h want 0", entry_count, oaram_value, oaram_index, oaram_address); else pass_cnt++;
    reset = 1'b0;
    c0 = cap_n; d0 = done_cnt;
    start_group(10'h050);
    beats[0] = 8'd6;
    send_beats(1, 1'b1);
    wait_done(d0);
    total_cnt++; if (cap_n - c0 !== 1) $display("FAIL mrst_writes got %0d want 1", cap_n - c0); else pass_cnt++;
    total_cnt++; if ({cap_val[c0], cap_idx[c0], cap_addr[c0]} !== {8'd6, 4'd0, 10'h050})
      $display("FAIL mrst_entry0 got %h/%h/%h want 06/0/050", cap_val[c0], cap_idx[c0], cap_addr[c0]); else pass_cnt++;
  endtask

  task automatic test_gap_and_start_ignored;
    int c0, d0;
    c0 = cap_n; d0 = done_cnt;
    start_group(10'h120);
    // Invalid beat carrying last and a new start must both be ignored.
    in_valid = 1'b0; in_value = 8'h55; in_last = 1'b1;
    start = 1'b1; base_address = 10'h300;
    @(negedge clk);
    start = 1'b0; in_last = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL gap_still_run got %0b want 1", in_ready); else pass_cnt++;
    beats[0] = 8'd8;
    send_beats(1, 1'b1);
    wait_done(d0);
    total_cnt++; if (cap_n - c0 !== 1) $display("FAIL gap_writes got %0d want 1", cap_n - c0); else pass_cnt++;
    total_cnt++; if ({cap_val[c0], cap_idx[c0], cap_addr[c0]} !== {8'd8, 4'd0, 10'h120})
      $display("FAIL gap_entry0 got %h/%h/%h want 08/0/120", cap_val[c0], cap_idx[c0], cap_addr[c0]); else pass_cnt++;
  endtask

  task automatic test_relu;
    int c0, d0;
    c0 = cap_n; d0 = done_cnt;
    start_group(10'h200);
    beats[0] = 8'hF0; beats[1] = 8'h04;
    send_beats(2, 1'b1);
    wait_done(d0);
`ifdef OARAM_PACKER_RELU_EN
    total_cnt++; if (cap_n - c0 !== 1) $display("FAIL relu_writes got %0d want 1", cap_n - c0); else pass_cnt++;
    total_cnt++; if ({cap_val[c0], cap_idx[c0], cap_addr[c0]} !== {8'h04, 4'd1, 10'h200})
      $display("FAIL relu_entry0 got %h/%h/%h want 04/1/200", cap_val[c0], cap_idx[c0], cap_addr[c0]); else pass_cnt++;
`else
    total_cnt++; if (cap_n - c0 !== 2) $display("FAIL raw_writes got %0d want 2", cap_n - c0); else pass_cnt++;
    total_cnt++; if ({cap_val[c0], cap_idx[c0], cap_addr[c0]} !== {8'hF0, 4'd0, 10'h200})
      $display("FAIL raw_entry0 got %h/%h/%h want f0/0/200", cap_val[c0], cap_idx[c0], cap_addr[c0]); else pass_cnt++;
    total_cnt++; if ({cap_val[c0+1], cap_idx[c0+1], cap_addr[c0+1]} !== {8'h04, 4'd0, 10'h201})
      $display("FAIL raw_entry1 got %h/%h/%h want 04/0/201", cap_val[c0+1], cap_idx[c0+1], cap_addr[c0+1]); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_placeholder;
    test_trailing;
    test_overflow;
    test_mid_reset;
    test_gap_and_start_ignored;
    test_relu;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
